// File: rtl/regfile_dbg_ctrl.sv
// Register-file write arbiter (core writeback over debug writes) and a debug
// dump engine that streams registers FIRST_REG..LAST_REG as valid/ready beats.
module regfile_dbg_ctrl #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_we_i,
  input  logic [4:0]  core_rd_i,
  input  logic [31:0] core_wd_i,
  input  logic        dbg_wr_req_i,
  input  logic [4:0]  dbg_wr_addr_i,
  input  logic [31:0] dbg_wr_data_i,
  output logic        dbg_wr_ack_o,
  input  logic        dump_start_i,
  output logic        dump_busy_o,
  output logic        dump_valid_o,
  input  logic        dump_ready_i,
  output logic [4:0]  dump_addr_o,
  output logic [31:0] dump_data_o,
  output logic        dump_done_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_rd_addr_o,
  output logic [31:0] rf_wd_o,
  output logic [4:0]  rf_dbg_addr_o,
  input  logic [31:0] rf_dbg_data_i
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  ptr_q, ptr_d;
  logic        valid_q, valid_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] capture;

  // Core writeback always wins; a debug write is acked only when the core is quiet.
  always_comb begin
    rf_we_o      = 1'b0;
    rf_rd_addr_o = '0;
    rf_wd_o      = '0;
    dbg_wr_ack_o = 1'b0;
    if (core_we_i) begin
      rf_we_o      = 1'b1;
      rf_rd_addr_o = core_rd_i;
      rf_wd_o      = core_wd_i;
    end else if (dbg_wr_req_i) begin
      rf_we_o      = (dbg_wr_addr_i != 5'd0);
      rf_rd_addr_o = dbg_wr_addr_i;
      rf_wd_o      = dbg_wr_data_i;
      dbg_wr_ack_o = 1'b1;
    end
  end

  // A write landing on the register being read this cycle is forwarded, so the
  // beat shows the value the register holds after this edge.
  assign capture = (rf_we_o && (rf_rd_addr_o == ptr_q) && (ptr_q != 5'd0))
                 ? rf_wd_o : rf_dbg_data_i;

  // Dump handshake: a beat transfers on a rising edge where dump_valid_o and
  // dump_ready_i are both high; while valid is high without ready, addr and
  // data are held unchanged, and valid never drops before the transfer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (dump_start_i) begin
          ptr_d   = FIRST_IDX;
          state_d = READ;
        end
      end
      READ: begin
        data_d  = capture;
        addr_d  = ptr_q;
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (valid_q && dump_ready_i) begin
          valid_d = 1'b0;
          if (ptr_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            ptr_d   = ptr_q + 5'd1;
            state_d = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign dump_busy_o   = (state_q != IDLE);
  assign dump_done_o   = (state_q == DONE);
  assign dump_valid_o  = valid_q;
  assign dump_addr_o   = addr_q;
  assign dump_data_o   = data_q;
  assign rf_dbg_addr_o = ptr_q;

endmodule

// File: tb/tb_regfile_dbg_ctrl.sv
// Self-checking bench for regfile_dbg_ctrl: directed scenarios followed by random
// traffic, checked against a register-level reference model and a beat queue.
module tb_regfile_dbg_ctrl;

  localparam int FIRST = 0;
  localparam int LAST  = 12;

  logic        clk;
  logic        rst = 1'b0;
  logic        core_we_i;
  logic [4:0]  core_rd_i;
  logic [31:0] core_wd_i;
  logic        dbg_wr_req_i;
  logic [4:0]  dbg_wr_addr_i;
  logic [31:0] dbg_wr_data_i;
  logic        dbg_wr_ack_o;
  logic        dump_start_i;
  logic        dump_busy_o;
  logic        dump_valid_o;
  logic        dump_ready_i;
  logic [4:0]  dump_addr_o;
  logic [31:0] dump_data_o;
  logic        dump_done_o;
  logic        rf_we_o;
  logic [4:0]  rf_rd_addr_o;
  logic [31:0] rf_wd_o;
  logic [4:0]  rf_dbg_addr_o;
  logic [31:0] rf_dbg_data_i;

  regfile_dbg_ctrl #(.FIRST_REG(FIRST), .LAST_REG(LAST)) dut (
    .clk(clk), .rst(rst),
    .core_we_i(core_we_i), .core_rd_i(core_rd_i), .core_wd_i(core_wd_i),
    .dbg_wr_req_i(dbg_wr_req_i), .dbg_wr_addr_i(dbg_wr_addr_i),
    .dbg_wr_data_i(dbg_wr_data_i), .dbg_wr_ack_o(dbg_wr_ack_o),
    .dump_start_i(dump_start_i), .dump_busy_o(dump_busy_o),
    .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i),
    .dump_addr_o(dump_addr_o), .dump_data_o(dump_data_o),
    .dump_done_o(dump_done_o),
    .rf_we_o(rf_we_o), .rf_rd_addr_o(rf_rd_addr_o), .rf_wd_o(rf_wd_o),
    .rf_dbg_addr_o(rf_dbg_addr_o), .rf_dbg_data_i(rf_dbg_data_i)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file seen by the DUT, written only through the DUT's write port.
  logic [31:0] env_rf [32] = '{default: 32'd0};
  always @(posedge clk) begin
    if (rf_we_o && rf_rd_addr_o != 5'd0) env_rf[rf_rd_addr_o] <= rf_wd_o;
  end
  assign rf_dbg_data_i = (rf_dbg_addr_o == 5'd0) ? 32'd0 : env_rf[rf_dbg_addr_o];

  // ---------------- reference model / scoreboard ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_rf [32];
  logic [4:0]  exp_q [$];
  logic        exp_valid, exp_busy, exp_done, pending;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic [4:0]  log_addr [$];
  logic [31:0] log_data [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clear_model_fsm();
    exp_q.delete();
    exp_valid = 1'b0;
    exp_busy  = 1'b0;
    exp_done  = 1'b0;
    pending   = 1'b0;
    exp_addr  = '0;
    exp_data  = '0;
  endtask

  task automatic check_arb();
    if (core_we_i) begin
      chk("arb_core_we", rf_we_o, 1'b1);
      chk("arb_core_ack", dbg_wr_ack_o, 1'b0);
      chk("arb_core_addr", rf_rd_addr_o, core_rd_i);
      chk("arb_core_data", rf_wd_o, core_wd_i);
    end else if (dbg_wr_req_i) begin
      chk("arb_dbg_ack", dbg_wr_ack_o, 1'b1);
      chk("arb_dbg_we", rf_we_o, (dbg_wr_addr_i != 5'd0));
      if (dbg_wr_addr_i != 5'd0) begin
        chk("arb_dbg_addr", rf_rd_addr_o, dbg_wr_addr_i);
        chk("arb_dbg_data", rf_wd_o, dbg_wr_data_i);
      end
    end else begin
      chk("arb_idle_we", rf_we_o, 1'b0);
      chk("arb_idle_ack", dbg_wr_ack_o, 1'b0);
    end
  endtask

  // One clock cycle: inputs are already set; check the write port, advance the
  // model across the edge, then check the dump outputs just after it.
  task automatic step();
    logic       hs, acc, wen;
    logic [4:0] wa;
    logic [31:0] wd;
    #1;
    check_arb();
    acc = dump_start_i && !exp_busy;
    hs  = exp_valid && dump_ready_i;
    if (hs) begin
      log_addr.push_back(dump_addr_o);
      log_data.push_back(dump_data_o);
    end
    wen = 1'b0;
    wa  = '0;
    wd  = '0;
    if (core_we_i) begin
      wen = (core_rd_i != 5'd0);
      wa  = core_rd_i;
      wd  = core_wd_i;
    end else if (dbg_wr_req_i) begin
      wen = (dbg_wr_addr_i != 5'd0);
      wa  = dbg_wr_addr_i;
      wd  = dbg_wr_data_i;
    end
    @(posedge clk);
    if (wen) model_rf[wa] = wd;
    if (exp_done) begin
      exp_done = 1'b0;
      exp_busy = 1'b0;
    end
    if (acc) begin
      exp_busy = 1'b1;
      for (int i = FIRST; i <= LAST; i++) exp_q.push_back(5'(i));
      pending = 1'b1;
    end else if (hs) begin
      void'(exp_q.pop_front());
      exp_valid = 1'b0;
      if (exp_q.size() == 0) exp_done = 1'b1;
      else pending = 1'b1;
    end else if (pending) begin
      pending   = 1'b0;
      exp_valid = 1'b1;
      exp_addr  = exp_q[0];
      exp_data  = model_rf[exp_q[0]];
    end
    #1;
    chk("dump_valid", dump_valid_o, exp_valid);
    chk("dump_busy", dump_busy_o, exp_busy);
    chk("dump_done", dump_done_o, exp_done);
    if (exp_valid) begin
      chk("dump_addr", dump_addr_o, exp_addr);
      chk("dump_data", dump_data_o, exp_data);
    end
    if (exp_busy && exp_q.size() != 0) chk("dbg_rd_addr", rf_dbg_addr_o, exp_q[0]);
  endtask

  task automatic set_idle_inputs();
    core_we_i     = 1'b0;
    core_rd_i     = '0;
    core_wd_i     = '0;
    dbg_wr_req_i  = 1'b0;
    dbg_wr_addr_i = '0;
    dbg_wr_data_i = '0;
    dump_start_i  = 1'b0;
  endtask

  task automatic do_reset();
    set_idle_inputs();
    rst = 1'b1;
    #1;
    chk("rst_valid", dump_valid_o, 1'b0);
    chk("rst_busy", dump_busy_o, 1'b0);
    chk("rst_done", dump_done_o, 1'b0);
    chk("rst_addr", dump_addr_o, 5'd0);
    chk("rst_data", dump_data_o, 32'd0);
    chk("rst_ptr", rf_dbg_addr_o, 5'd0);
    clear_model_fsm();
    @(posedge clk);
    #1;
    chk("rst_hold_done", dump_done_o, 1'b0);
    rst = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int hold;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    dump_ready_i = 1'b0;
    clear_model_fsm();
    set_idle_inputs();
    @(posedge clk);
    #1;
    do_reset();

    // Core and debug collide: core wins, then debug gets its ack.
    core_we_i = 1'b1; core_rd_i = 5'd5; core_wd_i = 32'h1111_1111;
    dbg_wr_req_i = 1'b1; dbg_wr_addr_i = 5'd6; dbg_wr_data_i = 32'h6666_6666;
    #1;
    chk("collide_we", rf_we_o, 1'b1);
    chk("collide_addr", rf_rd_addr_o, 5'd5);
    chk("collide_ack", dbg_wr_ack_o, 1'b0);
    step();
    core_we_i = 1'b0;
    #1;
    chk("dbg_turn_addr", rf_rd_addr_o, 5'd6);
    chk("dbg_turn_ack", dbg_wr_ack_o, 1'b1);
    step();

    // Debug write to x0 is acked but never reaches the register file.
    dbg_wr_addr_i = 5'd0; dbg_wr_data_i = 32'hFFFF_FFFF;
    #1;
    chk("dbg_x0_ack", dbg_wr_ack_o, 1'b1);
    chk("dbg_x0_we", rf_we_o, 1'b0);
    step();

    dbg_wr_req_i = 1'b0;
    core_we_i = 1'b1; core_rd_i = 5'd1; core_wd_i = 32'hDEAD_BEEF;
    step();
    core_we_i = 1'b0;
    dbg_wr_req_i = 1'b1; dbg_wr_addr_i = 5'd2; dbg_wr_data_i = 32'hCAFE_BABE;
    step();
    set_idle_inputs();

    // Full dump: stall beat 1 for five cycles, core writes x3 during its read.
    log_addr.delete(); log_data.delete();
    hold = 0;
    dump_ready_i = 1'b1;
    dump_start_i = 1'b1;
    step();
    dump_start_i = 1'b0;
    for (int c = 0; c < 200 && exp_busy; c++) begin
      core_we_i = 1'b0;
      if (pending && exp_q.size() != 0 && exp_q[0] == 5'd3) begin
        core_we_i = 1'b1; core_rd_i = 5'd3; core_wd_i = 32'hA5A5_A5A5;
      end
      if (exp_valid && exp_addr == 5'd1 && hold < 5) begin
        dump_ready_i = 1'b0;
        hold++;
        step();
        chk("stall_valid", dump_valid_o, 1'b1);
        chk("stall_addr", dump_addr_o, 5'd1);
        chk("stall_data", dump_data_o, 32'hDEAD_BEEF);
      end else begin
        dump_ready_i = 1'b1;
        step();
      end
    end
    core_we_i = 1'b0;
    chk("dump1_end_busy", dump_busy_o, 1'b0);
    chk("dump1_beats", log_addr.size(), LAST - FIRST + 1);
    if (log_addr.size() >= 4) begin
      chk("beat0_addr", log_addr[0], 5'd0);
      chk("beat0_data", log_data[0], 32'h0);
      chk("beat1_addr", log_addr[1], 5'd1);
      chk("beat1_data", log_data[1], 32'hDEAD_BEEF);
      chk("beat2_addr", log_addr[2], 5'd2);
      chk("beat2_data", log_data[2], 32'hCAFE_BABE);
      chk("beat3_bypass", log_data[3], 32'hA5A5_A5A5);
    end

    // Reset while holding beat 10 aborts the dump with no done pulse.
    log_addr.delete(); log_data.delete();
    dump_ready_i = 1'b1;
    dump_start_i = 1'b1;
    step();
    dump_start_i = 1'b0;
    for (int c = 0; c < 100 && !(exp_valid && exp_addr == 5'd10); c++) step();
    dump_ready_i = 1'b0;
    step();
    step();
    chk("pre_rst_addr", dump_addr_o, 5'd10);
    do_reset();
    step();
    chk("abort_no_done", dump_done_o, 1'b0);
    log_addr.delete(); log_data.delete();
    dump_ready_i = 1'b1;
    dump_start_i = 1'b1;
    step();
    dump_start_i = 1'b0;
    for (int c = 0; c < 100 && exp_busy; c++) step();
    chk("restart_end_busy", dump_busy_o, 1'b0);
    chk("restart_first_addr", (log_addr.size() != 0) ? 32'(log_addr[0]) : 32'hFFFF_FFFF, FIRST);

    // Random traffic: writes, stalls and stray start pulses mixed together.
    for (int c = 0; c < 600; c++) begin
      core_we_i     = ($urandom_range(0, 3) == 0);
      core_rd_i     = 5'($urandom_range(0, 15));
      core_wd_i     = $urandom();
      dbg_wr_req_i  = ($urandom_range(0, 2) == 0);
      dbg_wr_addr_i = 5'($urandom_range(0, 15));
      dbg_wr_data_i = $urandom();
      dump_start_i  = ($urandom_range(0, 7) == 0);
      dump_ready_i  = ($urandom_range(0, 1) == 1);
      step();
    end
    set_idle_inputs();
    dump_ready_i = 1'b1;
    for (int c = 0; c < 100 && exp_busy; c++) step();
    chk("drain_busy", dump_busy_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_dbg_ctrl.md
REGFILE_DBG_CTRL -- requirements
Module: regfile_dbg_ctrl

Interface
REQ-001 Parameter FIRST_REG, default 0, first register index streamed by a dump (0..31).
REQ-002 Parameter LAST_REG, default 31, last register index streamed by a dump (FIRST_REG..31).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 core_we_i  in  1  core writeback write enable.
REQ-006 core_rd_i  in  5  core writeback destination index.
REQ-007 core_wd_i  in  32  core writeback data.
REQ-008 dbg_wr_req_i  in  1  debug write request, held until acked.
REQ-009 dbg_wr_addr_i  in  5  debug write index.
REQ-010 dbg_wr_data_i  in  32  debug write data.
REQ-011 dbg_wr_ack_o  out  1  debug write granted this cycle.
REQ-012 dump_start_i  in  1  start register dump.
REQ-013 dump_busy_o  out  1  dump in progress.
REQ-014 dump_valid_o  out  1  dump beat valid.
REQ-015 dump_ready_i  in  1  dump beat accepted.
REQ-016 dump_addr_o  out  5  index of current beat.
REQ-017 dump_data_o  out  32  value of current beat.
REQ-018 dump_done_o  out  1  one-cycle pulse after the last beat.
REQ-019 rf_we_o / rf_rd_addr_o / rf_wd_o  out  1/5/32  register-file write port.
REQ-020 rf_dbg_addr_o  out  5  register-file debug read index; rf_dbg_data_i  in  32  its combinational read data.

Function
REQ-021 Write arbitration SHALL be combinational: core_we_i=1 -> port driven from core_*, dbg_wr_ack_o=0; else dbg_wr_req_i=1 -> port driven from dbg_*, dbg_wr_ack_o=1; else rf_we_o=0.
REQ-022 Debug write to index 0 SHALL be acked with rf_we_o=0.
REQ-023 Core write to index 0 SHALL pass through unchanged (register file ignores it).
REQ-024 Dump FSM states: IDLE, READ, SEND, DONE.
- IDLE: dump_start_i=1 -> ptr<=FIRST_REG, go READ.
- READ: rf_dbg_addr_o=ptr; at edge, dump_data_o<=captured value, dump_addr_o<=ptr, dump_valid_o<=1, go SEND.
- SEND: hold dump_valid_o/addr/data stable until dump_valid_o&dump_ready_i; then ptr==LAST_REG -> DONE (valid<=0), else ptr<=ptr+1, valid<=0, go READ.
- DONE: dump_done_o=1 for one cycle, go IDLE.
REQ-025 Captured value in READ SHALL be rf_wd_o if rf_we_o=1, rf_rd_addr_o==ptr and ptr!=0; otherwise rf_dbg_data_i (write bypass).
REQ-026 Latency: dump_start_i sampled at edge E0 -> dump_valid_o first high after E1; each further beat is valid one edge after the previous handshake (minimum 2 cycles/beat).
REQ-027 dump_busy_o SHALL be 1 in READ, SEND and DONE, 0 in IDLE.
REQ-028 dump_start_i SHALL be ignored outside IDLE.
REQ-029 rf_dbg_addr_o SHALL equal ptr in all states; ptr never exceeds LAST_REG.
REQ-030 Write arbitration SHALL be independent of dump state.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, ptr=0, dump_valid_o=0, dump_busy_o=0, dump_done_o=0, dump_addr_o=0, dump_data_o=0.
REQ-032 Reset mid-dump SHALL abort without a dump_done_o pulse; the next dump starts at FIRST_REG.

Verification
REQ-033 core_we_i=1,rd=5,wd=0x11111111 with dbg_wr_req_i=1,addr=6 -> rf_we_o=1, rf_rd_addr_o=5, dbg_wr_ack_o=0; next cycle core_we_i=0 -> rf_rd_addr_o=6, dbg_wr_ack_o=1.
REQ-034 Debug write addr=0,data=0xFFFFFFFF -> dbg_wr_ack_o=1, rf_we_o=0.
REQ-035 x1=0xDEADBEEF, x2=0xCAFEBABE, FIRST_REG=0, LAST_REG=2, dump_ready_i=1 -> beats (0,0x0),(1,0xDEADBEEF),(2,0xCAFEBABE), first valid 2 edges after start, dump_done_o pulse after beat 2.
REQ-036 dump_ready_i=0 for 5 cycles during beat 1 -> dump_valid_o, dump_addr_o=1, dump_data_o=0xDEADBEEF held constant for all 5 cycles.
REQ-037 Core write x3=0xA5A5A5A5 in the READ cycle for ptr=3 -> beat 3 data=0xA5A5A5A5.
REQ-038 rst pulse while in SEND at ptr=10 -> outputs zero immediately, no dump_done_o; new dump_start_i -> first beat addr=FIRST_REG.
